// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle receiver: FSM state encoding and default parameter values.
package toggle_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        STRETCH = 1'b1
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int PULSE_LEN_DEF   = 1;

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchronizer for a single asynchronous level; every stage resets to 0.
module toggle_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// Toggle-event receiver: synchronizes a remote toggle, stretches a pulse per event, acknowledges by toggling back.
// Optional event counter is built only when TOGGLE_RX_CNT_EN is defined; otherwise o_cnt is tied to 0.
module toggle_rx
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int PULSE_LEN   = PULSE_LEN_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_toggle,
    input  logic             clr_ovf,
    output logic             o_pulse,
    output logic             o_level,
    output logic             o_ack,
    output logic             o_busy,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [7:0] RELOAD = 8'(PULSE_LEN - 1);

    logic       level;
    logic       level_q;
    logic       evt;
    logic       retrig;
    state_t     state;
    state_t     state_nxt;
    logic [7:0] scnt;
    logic [7:0] scnt_nxt;
    logic       ack;
    logic       ovf;

    toggle_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rstn(rstn),
        .d   (i_toggle),
        .q   (level)
    );

    // Any difference between the synchronized level and its one-cycle-old copy is one event.
    assign evt    = level ^ level_q;
    assign retrig = evt && (state == STRETCH);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        case (state)
            IDLE: begin
                if (evt) begin
                    state_nxt = STRETCH;
                    scnt_nxt  = RELOAD;
                end
            end
            STRETCH: begin
                if (evt) begin
                    scnt_nxt = RELOAD;
                end else if (scnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    scnt_nxt = scnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= 1'b0;
            state   <= IDLE;
            scnt    <= 8'd0;
            ack     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            level_q <= level;
            state   <= state_nxt;
            scnt    <= scnt_nxt;
            if (evt) begin
                ack <= ~ack;
            end
            // A retrigger takes priority over a coincident clear.
            if (retrig) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef TOGGLE_RX_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (evt) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_cnt = cnt;
`else
    assign o_cnt = '0;
`endif

    assign o_busy  = (state == STRETCH);
    assign o_pulse = o_busy;
    assign o_level = level;
    assign o_ack   = ack;
    assign o_ovf   = ovf;

endmodule
